// File: rtl/mul_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_seq
// Brief    : Multicycle signed multiply (radix-2 Booth) / divide (restoring)
//            sequencer producing HI/LO. Optional MULDIV_UNSIGNED_EN adds
//            op_unsigned for multu/divu.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Product register: {upper (WIDTH+2), multiplier (WIDTH+1), booth bit}
    localparam int c_PW = 2*WIDTH + 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_FIX  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_uns;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt;
    logic [c_PW-1:0]  r_prod;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_bmag;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_uns_in;
    logic             w_b_zero;
    logic [WIDTH+1:0] w_mcand;
    logic [WIDTH+1:0] w_upper;
    logic [WIDTH+1:0] w_upper_nx;
    logic [c_PW-1:0]  w_prod_nx;
    logic [WIDTH:0]   w_b_ext;
    logic [2*WIDTH-1:0] w_prod_res;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef MULDIV_UNSIGNED_EN
    assign w_uns_in = op_unsigned;
`else
    assign w_uns_in = 1'b0;
`endif

    assign w_b_zero = (r_b == '0);

    // Booth step; upper half is WIDTH+2 bits so a zero-extended or most
    // negative multiplicand cannot overflow the accumulation.
    assign w_mcand = r_uns ? {2'b00, r_a} : {{2{r_a[WIDTH-1]}}, r_a};
    assign w_upper = r_prod[c_PW-1 -: WIDTH+2];

    always_comb begin
        w_upper_nx = w_upper;
        case (r_prod[1:0])
            2'b01:   w_upper_nx = w_upper + w_mcand;
            2'b10:   w_upper_nx = w_upper - w_mcand;
            default: w_upper_nx = w_upper;
        endcase
    end

    assign w_prod_nx = {w_upper_nx[WIDTH+1], w_upper_nx, r_prod[WIDTH+1:1]};
    assign w_b_ext   = r_uns ? {1'b0, r_b} : {r_b[WIDTH-1], r_b};

    // Signed runs WIDTH shifts (product lands at bit 2), unsigned runs
    // WIDTH+1 shifts (product lands at bit 1).
    assign w_prod_res = r_uns ? r_prod[2*WIDTH:1] : r_prod[2*WIDTH+1:2];

    assign w_amag = (!r_uns && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_bmag = (!r_uns && r_b[WIDTH-1]) ? -r_b : r_b;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = {1'b0, w_rem_sh} - {2'b00, r_bmag};

    assign w_q_fix = (!r_uns && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -r_quo : r_quo;
    assign w_r_fix = (!r_uns && r_a[WIDTH-1]) ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (r_op && w_b_zero) begin
                    w_state_nx = S_FIN;
                end else if (r_op) begin
                    w_state_nx = S_DIV;
                end else begin
                    w_state_nx = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_FIX;
                end
            end
            S_FIX: begin
                busy       = 1'b1;
                w_state_nx = S_FIN;
            end
            S_FIN: begin
                done       = 1'b1;
                div_zero   = r_dz;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= 1'b0;
            r_uns  <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_bmag <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_uns <= w_uns_in;
                    end
                end
                S_LOAD: begin
                    r_dz <= r_op && w_b_zero;
                    if (r_op) begin
                        r_rem  <= '0;
                        r_quo  <= w_amag;
                        r_bmag <= w_bmag;
                        r_cnt  <= CNT_W'(WIDTH);
                    end else begin
                        r_prod <= {{(WIDTH+2){1'b0}}, w_b_ext, 1'b0};
                        r_cnt  <= r_uns ? CNT_W'(WIDTH+1) : CNT_W'(WIDTH);
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod_nx;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                S_DIV: begin
                    if (!w_trial[WIDTH+1]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    if (r_op) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_res[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_res[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_seq
// Brief    : Directed self-checking bench for mul_div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
`ifdef MULDIV_UNSIGNED_EN
    logic        op_unsigned;
`endif
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
`ifdef MULDIV_UNSIGNED_EN
        .op_unsigned(op_unsigned),
`endif
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge while the DUT is idle. inj > 0 pulses a
    // spurious start with different operands in that cycle of the operation.
    task automatic run_op(input string tag, input logic o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz, input int elat,
                          input int inj);
        int cyc;
        int nbusy;
        bit seen;
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        @(posedge clk); #1;
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        cyc   = 1;
        nbusy = 0;
        seen  = 0;
        while (cyc <= 60) begin
            if (cyc == inj) begin
                start = 1'b1;
                op    = ~o;
                a     = 32'h9;
                b     = 32'h9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_lat"},   seen ? 64'(cyc) : 64'hFFFF, 64'(elat));
        check({tag, "_nbusy"}, 64'(nbusy), 64'(elat - 1));
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"},    {32'd0, hi}, {32'd0, eh});
        check({tag, "_lo"},    {32'd0, lo}, {32'd0, el});
        check({tag, "_dz"},    {63'd0, div_zero}, {63'd0, edz});
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
`ifdef MULDIV_UNSIGNED_EN
        op_unsigned = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_outputs", {61'd0, busy, done, div_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        run_op("mul_7_m3",     1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35, 0);
        run_op("mul_min_min",  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35, 0);
        run_op("mul_max_min",  1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 35, 0);
        run_op("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35, 0);
        run_op("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35, 0);
        run_op("div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35, 0);
        run_op("div_preload",  1'b1, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 1'b0, 35, 0);
        run_op("div_zero",     1'b1, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 1'b1, 2,  0);
        run_op("mul_inj",      1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1'b0, 35, 10);

        // Abort a mult with reset in cycle 20.
        start = 1'b1;
        op    = 1'b0;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        run_op("mul_after_rst", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35, 0);

`ifdef MULDIV_UNSIGNED_EN
        op_unsigned = 1'b1;
        run_op("divu", 1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 1'b0, 35, 0);
        run_op("multu", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 36, 0);
        op_unsigned = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
